// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, branch flush and ID-stage forwarding control with EX/MEM shadow state.
// Optional performance counters when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
  parameter int FLUSH_CYCLES = 1
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       usert,
  input  logic       dwreg,
  input  logic       dm2reg,
  input  logic [4:0] drn,
  input  logic       dbranch,
  output logic       wpcir,
  output logic       if_flush,
  output logic [1:0] fwda,
  output logic [1:0] fwdb
`ifdef PIPE_HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt_tot
`endif
);
  logic [4:0] e_rn_q, e_rn_d, m_rn_q;
  logic       e_wreg_q, e_wreg_d, e_m2reg_q, e_m2reg_d;
  logic       m_wreg_q, m_m2reg_q;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       stall, bubble;
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] ern, input logic ew,
                                         input logic em, input logic [4:0] mrn, input logic mw, input logic mm);
    return (ew & (ern != '0) & (ern == src) & ~em) ? 2'b01 :
           (mw & (mrn != '0) & (mrn == src)) ? (mm ? 2'b11 : 2'b10) : 2'b00;
  endfunction
  assign stall    = e_wreg_q & e_m2reg_q & (e_rn_q != '0) & ((e_rn_q == rs) | (usert & (e_rn_q == rt)));
  assign wpcir    = ~stall;
  assign if_flush = (dbranch & ~stall) | (flush_cnt_q != '0);
  assign bubble   = stall | if_flush;
  assign fwda     = fwd_sel(rs, e_rn_q, e_wreg_q, e_m2reg_q, m_rn_q, m_wreg_q, m_m2reg_q);
  assign fwdb     = fwd_sel(rt, e_rn_q, e_wreg_q, e_m2reg_q, m_rn_q, m_wreg_q, m_m2reg_q);
  always_comb begin
    e_rn_d      = bubble ? e_rn_q : drn;
    e_wreg_d    = ~bubble & dwreg;
    e_m2reg_d   = ~bubble & dm2reg;
    flush_cnt_d = (dbranch & ~stall & (flush_cnt_q == '0)) ? 3'(FLUSH_CYCLES - 1) :
                  (flush_cnt_q != '0) ? flush_cnt_q - 3'd1 : flush_cnt_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      e_rn_q      <= '0;
      e_wreg_q    <= 1'b0;
      e_m2reg_q   <= 1'b0;
      m_rn_q      <= '0;
      m_wreg_q    <= 1'b0;
      m_m2reg_q   <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      e_rn_q      <= e_rn_d;
      e_wreg_q    <= e_wreg_d;
      e_m2reg_q   <= e_m2reg_d;
      m_rn_q      <= e_rn_q;
      m_wreg_q    <= e_wreg_q;
      m_m2reg_q   <= e_m2reg_q;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_tot_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      flush_tot_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
      flush_tot_q <= flush_tot_q + CNT_W'(if_flush);
    end
  end
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt_tot = flush_tot_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scoreboard bench for pipe_hazard_unit with FLUSH_CYCLES=2.
module tb_pipe_hazard_unit;
  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] rs, rt, drn;
  logic       usert, dwreg, dm2reg, dbranch;
  logic       wpcir, if_flush;
  logic [1:0] fwda, fwdb;
  int total = 0;
  int bad = 0;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt_tot;
`endif
  typedef struct {
    logic       w;
    logic       f;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sb[$];
  pipe_hazard_unit #(.FLUSH_CYCLES(2)) dut (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .usert(usert),
    .dwreg(dwreg), .dm2reg(dm2reg), .drn(drn), .dbranch(dbranch),
    .wpcir(wpcir), .if_flush(if_flush), .fwda(fwda), .fwdb(fwdb)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt_tot(flush_cnt_tot)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic rn, input logic [4:0] s, input logic [4:0] t,
                      input logic ut, input logic w, input logic m, input logic [4:0] d, input logic br,
                      input logic ew, input logic ef, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    resetn = rn; rs = s; rt = t; usert = ut; dwreg = w; dm2reg = m; drn = d; dbranch = br;
    sb.push_back('{w: ew, f: ef, a: ea, b: eb});
    @(negedge clock);
    if (sb.size() == 0) chk({tag, "_empty"}, 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk({tag, "_wpcir"}, 32'(wpcir), 32'(e.w));
      chk({tag, "_flush"}, 32'(if_flush), 32'(e.f));
      chk({tag, "_fwda"}, 32'(fwda), 32'(e.a));
      chk({tag, "_fwdb"}, 32'(fwdb), 32'(e.b));
    end
    @(posedge clock);
    #1;
  endtask
  initial begin
    resetn = 1'b0; rs = '0; rt = '0; usert = 1'b0; dwreg = 1'b0; dm2reg = 1'b0; drn = '0; dbranch = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    //    tag         rn  rs  rt  ut w  m  drn br   w  f  a      b
    step("rst",       1, 0,  0,  0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("lw5",       1, 0,  0,  0, 1, 1, 5,  0,   1, 0, 2'b00, 2'b00);
    step("lu_stall",  1, 5,  0,  0, 1, 0, 6,  0,   0, 0, 2'b00, 2'b00);
    step("lu_fwd",    1, 5,  0,  0, 1, 0, 6,  0,   1, 0, 2'b11, 2'b00);
    step("add3",      1, 0,  0,  0, 1, 0, 3,  0,   1, 0, 2'b00, 2'b00);
    step("alu_ex",    1, 3,  3,  1, 0, 0, 0,  0,   1, 0, 2'b01, 2'b01);
    step("alu_mem",   1, 3,  3,  0, 0, 0, 0,  0,   1, 0, 2'b10, 2'b10);
    step("w0",        1, 0,  0,  0, 1, 1, 0,  0,   1, 0, 2'b00, 2'b00);
    step("r0_use",    1, 0,  0,  1, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("r0_mem",    1, 0,  0,  0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("p1",        1, 0,  0,  0, 1, 0, 7,  0,   1, 0, 2'b00, 2'b00);
    step("p2",        1, 7,  0,  0, 1, 0, 7,  0,   1, 0, 2'b01, 2'b00);
    step("p3_exwin",  1, 7,  0,  0, 0, 0, 0,  0,   1, 0, 2'b01, 2'b00);
    step("p4",        1, 7,  7,  0, 0, 0, 0,  0,   1, 0, 2'b10, 2'b10);
    step("br0",       1, 0,  0,  0, 1, 0, 9,  1,   1, 1, 2'b00, 2'b00);
    step("br1_ign",   1, 0,  0,  0, 1, 0, 9,  1,   1, 1, 2'b00, 2'b00);
    step("br2",       1, 9,  0,  0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("sb_lw",     1, 0,  0,  0, 1, 1, 4,  0,   1, 0, 2'b00, 2'b00);
    step("sb_hold",   1, 4,  0,  0, 0, 0, 0,  1,   0, 0, 2'b00, 2'b00);
    step("sb_go",     1, 4,  0,  0, 0, 0, 0,  1,   1, 1, 2'b11, 2'b00);
    step("sb_tail",   1, 0,  0,  0, 0, 0, 0,  0,   1, 1, 2'b00, 2'b00);
    step("sb_end",    1, 0,  0,  0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("rm_lw",     1, 0,  0,  0, 1, 1, 8,  0,   1, 0, 2'b00, 2'b00);
    step("rm_br",     1, 0,  0,  0, 0, 0, 0,  1,   1, 1, 2'b00, 2'b00);
    step("rm_rst",    0, 8,  0,  0, 0, 0, 0,  0,   1, 1, 2'b11, 2'b00);
`ifdef PIPE_HAZARD_PERF_EN
    resetn = 1'b1; rs = 5'd8; rt = 5'd8; usert = 1'b1;
    @(negedge clock);
    chk("perf_stall", stall_cnt, 32'd0);
    chk("perf_flush", flush_cnt_tot, 32'd0);
    @(posedge clock);
    #1;
    step("rm_after2", 1, 8,  8,  1, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
`else
    step("rm_after",  1, 8,  8,  1, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
`endif
    step("rs_lw",     1, 0,  0,  0, 1, 1, 2,  0,   1, 0, 2'b00, 2'b00);
    step("rs_stall",  0, 2,  0,  0, 0, 0, 0,  0,   0, 0, 2'b00, 2'b00);
    step("rs_after",  1, 2,  0,  0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("ut_lw",     1, 0,  0,  0, 1, 1, 10, 0,   1, 0, 2'b00, 2'b00);
    step("ut_nouse",  1, 0,  10, 0, 0, 0, 0,  0,   1, 0, 2'b00, 2'b00);
    step("ut_lw2",    1, 0,  0,  0, 1, 1, 11, 0,   1, 0, 2'b00, 2'b00);
    step("ut_use",    1, 0,  11, 1, 0, 0, 0,  0,   0, 0, 2'b00, 2'b00);
    step("ut_fwd",    1, 0,  11, 1, 0, 0, 0,  0,   1, 0, 2'b00, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
